// File: rtl/rect_renderer_pkg.sv
// rtl/rect_renderer_pkg.sv - shared widths, constants, slot record and FSM states for rect_renderer
package rect_renderer_pkg;

  localparam int RECT_W  = 10;
  localparam int COLOR_W = 6;
  localparam logic [RECT_W-1:0] COORD_INV = 10'h3FF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic               en;
    logic [RECT_W-1:0]  x0;
    logic [RECT_W-1:0]  x1;
    logic [RECT_W-1:0]  y0;
    logic [RECT_W-1:0]  y1;
    logic [COLOR_W-1:0] color;
  } slot_t;

endpackage

// File: rtl/rect_renderer_hit.sv
// rtl/rect_renderer_hit.sv - one slot's combinational inclusive bounds comparator
module rect_renderer_hit
  import rect_renderer_pkg::*;
(
  input  logic              en_i,
  input  logic [RECT_W-1:0] x0_i,
  input  logic [RECT_W-1:0] x1_i,
  input  logic [RECT_W-1:0] y0_i,
  input  logic [RECT_W-1:0] y1_i,
  input  logic [RECT_W-1:0] x_i,
  input  logic [RECT_W-1:0] y_i,
  output logic              hit_o
);

  // Inverted bounds fail one of the two compares naturally, so they never hit.
  assign hit_o = en_i && (x_i != COORD_INV) && (y_i != COORD_INV) &&
                 (x0_i <= x_i) && (x_i <= x1_i) &&
                 (y0_i <= y_i) && (y_i <= y1_i);

endmodule

// File: rtl/rect_renderer.sv
// rtl/rect_renderer.sv - double-buffered rectangle table with a fixed 2-clock x/y to RGB pipeline
module rect_renderer
  import rect_renderer_pkg::*;
#(
  parameter int                 N_RECT   = 8,
  parameter logic [COLOR_W-1:0] BG_COLOR = 6'h00
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [RECT_W-1:0]         x,
  input  logic [RECT_W-1:0]         y,
  input  logic                      active,
  input  logic                      frame_start,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_clear,
  input  logic [$clog2(N_RECT)-1:0] cmd_slot,
  input  logic                      cmd_en,
  input  logic [RECT_W-1:0]         cmd_x0,
  input  logic [RECT_W-1:0]         cmd_x1,
  input  logic [RECT_W-1:0]         cmd_y0,
  input  logic [RECT_W-1:0]         cmd_y1,
  input  logic [COLOR_W-1:0]        cmd_color,
  output logic [COLOR_W-1:0]        RGB,
  output logic                      commit_done
);

  localparam int SW = $clog2(N_RECT);

  slot_t               shadow_q [N_RECT];
  slot_t               live_q   [N_RECT];
  state_e              state_q;
  logic [SW-1:0]       cnt_q;
  logic                pending_q;
  logic                commit_done_q;

  logic [N_RECT-1:0]   hit;
  logic [N_RECT-1:0]   hit_q;
  logic                active_q;
  logic [COLOR_W-1:0]  color_q [N_RECT];
  logic [COLOR_W-1:0]  win_color;
  logic [COLOR_W-1:0]  rgb_q;

  logic                commit_now;
  logic                cmd_fire;

  // A commit takes priority over a command in the same cycle; the command just waits.
  assign commit_now  = (state_q == ST_IDLE) && (pending_q || frame_start);
  assign cmd_ready   = !reset && (state_q == ST_IDLE) && !commit_now;
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign commit_done = commit_done_q;
  assign RGB         = rgb_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      for (int i = 0; i < N_RECT; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
    end else begin
      commit_done_q <= commit_now;
      if (commit_now) begin
        live_q    <= shadow_q;
        pending_q <= 1'b0;
      end else if (frame_start) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (cmd_clear) begin
              state_q <= ST_CLEAR;
              cnt_q   <= '0;
            end else begin
              shadow_q[cmd_slot] <= '{en: cmd_en, x0: cmd_x0, x1: cmd_x1,
                                      y0: cmd_y0, y1: cmd_y1, color: cmd_color};
            end
          end
        end
        ST_CLEAR: begin
          shadow_q[cnt_q].en <= 1'b0;
          cnt_q              <= cnt_q + 1'b1;
          if (cnt_q == SW'(N_RECT - 1)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_RECT; g++) begin : g_hit
    rect_renderer_hit u_hit (
      .en_i  (live_q[g].en),
      .x0_i  (live_q[g].x0),
      .x1_i  (live_q[g].x1),
      .y0_i  (live_q[g].y0),
      .y1_i  (live_q[g].y1),
      .x_i   (x),
      .y_i   (y),
      .hit_o (hit[g])
    );
  end

  // Lowest index wins, so scan from the top down and let lower slots overwrite.
  always_comb begin
    win_color = BG_COLOR;
    for (int i = N_RECT - 1; i >= 0; i--) begin
      if (hit_q[i]) win_color = color_q[i];
    end
  end

  // Colours are captured alongside the hits so a commit never splits a pixel's view of the table.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hit_q    <= '0;
      active_q <= 1'b0;
      rgb_q    <= '0;
      for (int i = 0; i < N_RECT; i++) color_q[i] <= '0;
    end else begin
      hit_q    <= hit;
      active_q <= active;
      for (int i = 0; i < N_RECT; i++) color_q[i] <= live_q[i].color;
      rgb_q    <= active_q ? win_color : '0;
    end
  end

endmodule

// File: tb/tb_rect_renderer.sv
// tb/tb_rect_renderer.sv - directed scoreboard bench for rect_renderer
module tb_rect_renderer;

  localparam logic [5:0] BG = 6'h15;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       active;
  logic       frame_start;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_clear;
  logic [2:0] cmd_slot;
  logic       cmd_en;
  logic [9:0] cmd_x0, cmd_x1, cmd_y0, cmd_y1;
  logic [5:0] cmd_color;
  logic [5:0] RGB;
  logic       commit_done;

  int checks = 0;
  int errors = 0;
  int pix_idx = 0;
  logic [6:0] exp_q [$];

  always #5 clk = ~clk;

  rect_renderer #(.N_RECT(8), .BG_COLOR(BG)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .active      (active),
    .frame_start (frame_start),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_clear   (cmd_clear),
    .cmd_slot    (cmd_slot),
    .cmd_en      (cmd_en),
    .cmd_x0      (cmd_x0),
    .cmd_x1      (cmd_x1),
    .cmd_y0      (cmd_y0),
    .cmd_y1      (cmd_y1),
    .cmd_color   (cmd_color),
    .RGB         (RGB),
    .commit_done (commit_done)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel monitor: RGB after edge k reflects the inputs sampled at edge k-1.
  initial begin : monitor
    logic [6:0] s1;
    logic       have;
    have = 1'b0;
    s1   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (have && s1[6]) begin
        check($sformatf("pixel%0d", pix_idx), {2'b00, RGB}, {2'b00, s1[5:0]});
        pix_idx++;
      end
      if (exp_q.size() > 0) begin
        s1   = exp_q.pop_front();
        have = 1'b1;
      end else begin
        have = 1'b0;
      end
    end
  end

  task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic a, input logic [5:0] e);
    @(negedge clk);
    x = px;
    y = py;
    active = a;
    exp_q.push_back({1'b1, e});
  endtask

  task automatic send_cmd(input logic clr, input logic [2:0] slot, input logic [9:0] x0,
                          input logic [9:0] x1, input logic [9:0] y0, input logic [9:0] y1,
                          input logic [5:0] col);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_clear = clr;
    cmd_slot  = slot;
    cmd_en    = 1'b1;
    cmd_x0 = x0; cmd_x1 = x1; cmd_y0 = y0; cmd_y1 = y1;
    cmd_color = col;
    #1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) check("cmd_accept_timeout", {7'd0, cmd_ready}, 8'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic commit(input string tag);
    @(negedge clk);
    frame_start = 1'b1;
    #1;
    check({tag, "_ready_low"}, {7'd0, cmd_ready}, 8'd0);
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    check({tag, "_done"}, {7'd0, commit_done}, 8'd1);
    @(negedge clk);
    #1;
    check({tag, "_done_drop"}, {7'd0, commit_done}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; x = '0; y = '0; active = 1'b0; frame_start = 1'b0;
    cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_slot = '0; cmd_en = 1'b0;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {7'd0, cmd_ready}, 8'd0);
    check("rst_rgb", {2'b00, RGB}, 8'h00);
    check("rst_done", {7'd0, commit_done}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", {7'd0, cmd_ready}, 8'd1);

    // Empty table: background when active, black when not.
    pix(100, 100, 1'b1, BG);
    pix(100, 100, 1'b1, BG);
    pix(100, 100, 1'b0, 6'h00);

    // Shadow write stays invisible until committed.
    send_cmd(1'b0, 3'd0, 10, 20, 10, 20, 6'h30);
    pix(15, 15, 1'b1, BG);
    commit("c1");
    pix(15, 15, 1'b1, 6'h30);
    pix(10, 10, 1'b1, 6'h30);
    pix(20, 20, 1'b1, 6'h30);
    pix(21, 15, 1'b1, BG);
    pix(15, 9, 1'b1, BG);

    // Overlap priority, invalid coordinates, inverted bounds.
    send_cmd(1'b0, 3'd1, 0, 639, 0, 479, 6'h0C);
    send_cmd(1'b0, 3'd2, 700, 600, 0, 479, 6'h3F);
    commit("c2");
    pix(15, 15, 1'b1, 6'h30);
    pix(300, 300, 1'b1, 6'h0C);
    pix(10'h3FF, 15, 1'b1, BG);
    pix(15, 10'h3FF, 1'b1, BG);
    pix(650, 10, 1'b1, BG);
    pix(300, 300, 1'b0, 6'h00);

    // Clear with two frame_start pulses landing mid-CLEAR: exactly one deferred commit.
    send_cmd(1'b1, 3'd0, 0, 0, 0, 0, 6'h00);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      frame_start = (i == 2 || i == 4);
      #1;
      if (i <= 8) begin
        check($sformatf("clr_ready_c%0d", i), {7'd0, cmd_ready}, 8'd0);
        check($sformatf("clr_done_c%0d", i), {7'd0, commit_done}, 8'd0);
      end else if (i == 9) begin
        check("clr_commit_ready", {7'd0, cmd_ready}, 8'd0);
        check("clr_commit_pre", {7'd0, commit_done}, 8'd0);
      end else if (i == 10) begin
        check("clr_commit_done", {7'd0, commit_done}, 8'd1);
        check("clr_ready_back", {7'd0, cmd_ready}, 8'd1);
      end else begin
        check("clr_single_commit", {7'd0, commit_done}, 8'd0);
      end
    end
    pix(15, 15, 1'b1, BG);
    pix(300, 300, 1'b1, BG);

    // Command coincident with frame_start stalls one cycle and misses that commit.
    @(negedge clk);
    frame_start = 1'b1;
    cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_slot = 3'd3; cmd_en = 1'b1;
    cmd_x0 = 100; cmd_x1 = 110; cmd_y0 = 100; cmd_y1 = 110; cmd_color = 6'h2A;
    #1;
    check("coinc_ready_low", {7'd0, cmd_ready}, 8'd0);
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    check("coinc_done", {7'd0, commit_done}, 8'd1);
    check("coinc_ready_high", {7'd0, cmd_ready}, 8'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    pix(105, 105, 1'b1, BG);
    pix(105, 105, 1'b1, BG);
    commit("c3");
    pix(105, 105, 1'b1, 6'h2A);
    pix(99, 105, 1'b1, BG);

    // Reset in the middle of a clear.
    send_cmd(1'b1, 3'd0, 0, 0, 0, 0, 6'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("midclr_rst_ready", {7'd0, cmd_ready}, 8'd0);
    check("midclr_rst_rgb", {2'b00, RGB}, 8'h00);
    reset = 1'b0;
    #1;
    check("midclr_ready", {7'd0, cmd_ready}, 8'd1);
    pix(105, 105, 1'b1, BG);
    pix(105, 105, 1'b0, 6'h00);
    commit("c4");
    pix(105, 105, 1'b1, BG);
    repeat (4) @(negedge clk);
    check("scoreboard_drained", {7'd0, exp_q.size() == 0}, 8'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
